axi_arbiter: RTL and testbench

Two-master, one-slave arbiter for the single memory port behind the DPI pmem model. Shares the port between the instruction fetch unit (master 0, read-only) and the load/store unit (master 1, read and write). Allows one outstanding transaction at a time and routes its handshakes between the granted master and the slave. Sits between the IFU/LSU memory interfaces and the memory-side bus.

---
 rtl/axi_arb_pkg.sv | 18 +
 rtl/arb_pick.sv | 33 +++
 rtl/axi_arbiter.sv | 168 ++++++++++++++++
 tb/tb_axi_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master pmem port arbiter.
// Build option ARB_RR_EN selects round-robin arbitration between the masters.
package axi_arb_pkg;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 64;

   localparam logic MST_M0 = 1'b0;
   localparam logic MST_M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_M0 = 2'd1,
      RD_M1 = 2'd2,
      WR_M1 = 2'd3
   } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational next-grant selection among the pending IFU/LSU requests.
// ARB_RR_EN: the m0/m1 choice follows rr_ptr; otherwise fixed WR_M1 > RD_M1 > RD_M0.
module arb_pick
   import axi_arb_pkg::*;
(
   input  logic       m0_rd_req,
   input  logic       m1_rd_req,
   input  logic       m1_wr_req,
`ifdef ARB_RR_EN
   input  logic       rr_ptr,
`endif
   output arb_state_t grant
);

   always_comb begin
      grant = IDLE;
`ifdef ARB_RR_EN
      // m1 wins when it has the pointer or m0 is not asking; a store still beats a load.
      if ((m1_wr_req || m1_rd_req) && (rr_ptr == MST_M1 || !m0_rd_req))
         grant = m1_wr_req ? WR_M1 : RD_M1;
      else if (m0_rd_req)
         grant = RD_M0;
`else
      if (m1_wr_req)
         grant = WR_M1;
      else if (m1_rd_req)
         grant = RD_M1;
      else if (m0_rd_req)
         grant = RD_M0;
`endif
   end

endmodule

// File: rtl/axi_arbiter.sv
// Shares the single pmem port between the IFU (m0, reads) and LSU (m1, reads/writes).
// One transaction in flight; define ARB_RR_EN for round-robin between m0 and m1.
module axi_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ADDR_W = AXI_ADDR_W,
   parameter int DATA_W = AXI_DATA_W
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   input  logic [ADDR_W-1:0]   m0_araddr,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   output logic [DATA_W-1:0]   m0_rdata,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   input  logic [ADDR_W-1:0]   m1_araddr,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   output logic [DATA_W-1:0]   m1_rdata,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   output logic                s_arvalid,
   input  logic                s_arready,
   output logic [ADDR_W-1:0]   s_araddr,
   input  logic                s_rvalid,
   output logic                s_rready,
   input  logic [DATA_W-1:0]   s_rdata,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic                s_wvalid,
   input  logic                s_wready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_bvalid,
   output logic                s_bready
);

   arb_state_t state, state_nx, pick_grant;
   logic       ar_done, ar_done_nx;
   logic       aw_done, aw_done_nx;
   logic       w_done, w_done_nx;
   logic       xfer_done;

`ifdef ARB_RR_EN
   logic       rr_ptr;
`endif

   arb_pick u_pick (
      .m0_rd_req (m0_arvalid),
      .m1_rd_req (m1_arvalid),
      .m1_wr_req (m1_awvalid),
`ifdef ARB_RR_EN
      .rr_ptr    (rr_ptr),
`endif
      .grant     (pick_grant)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state   <= IDLE;
         ar_done <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_nx;
         ar_done <= ar_done_nx;
         aw_done <= aw_done_nx;
         w_done  <= w_done_nx;
      end
   end

`ifdef ARB_RR_EN
   // After a completed grant the other master gets first claim.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)
         rr_ptr <= MST_M0;
      else if (xfer_done)
         rr_ptr <= (state == RD_M0) ? MST_M1 : MST_M0;
   end
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx   = state;
      ar_done_nx = ar_done;
      aw_done_nx = aw_done;
      w_done_nx  = w_done;
      xfer_done  = 1'b0;
      m0_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m0_rdata   = '0;
      m1_arready = 1'b0;
      m1_rvalid  = 1'b0;
      m1_rdata   = '0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bvalid  = 1'b0;
      s_arvalid  = 1'b0;
      s_araddr   = '0;
      s_rready   = 1'b0;
      s_awvalid  = 1'b0;
      s_awaddr   = '0;
      s_wvalid   = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_bready   = 1'b0;

      case (state)
         IDLE: state_nx = pick_grant;
         RD_M0: begin
            s_arvalid  = m0_arvalid && !ar_done;
            s_araddr   = m0_araddr;
            m0_arready = s_arready && !ar_done;
            s_rready   = m0_rready;
            m0_rvalid  = s_rvalid;
            m0_rdata   = s_rdata;
            if (s_arvalid && s_arready) ar_done_nx = 1'b1;
            xfer_done  = s_rvalid && m0_rready;
         end
         RD_M1: begin
            s_arvalid  = m1_arvalid && !ar_done;
            s_araddr   = m1_araddr;
            m1_arready = s_arready && !ar_done;
            s_rready   = m1_rready;
            m1_rvalid  = s_rvalid;
            m1_rdata   = s_rdata;
            if (s_arvalid && s_arready) ar_done_nx = 1'b1;
            xfer_done  = s_rvalid && m1_rready;
         end
         WR_M1: begin
            // AW and W run independently; each is issued only until its own handshake.
            s_awvalid  = m1_awvalid && !aw_done;
            s_awaddr   = m1_awaddr;
            m1_awready = s_awready && !aw_done;
            s_wvalid   = m1_wvalid && !w_done;
            s_wdata    = m1_wdata;
            s_wstrb    = m1_wstrb;
            m1_wready  = s_wready && !w_done;
            s_bready   = m1_bready;
            m1_bvalid  = s_bvalid;
            if (s_awvalid && s_awready) aw_done_nx = 1'b1;
            if (s_wvalid && s_wready) w_done_nx = 1'b1;
            xfer_done  = s_bvalid && m1_bready;
         end
         default: state_nx = IDLE;
      endcase

      if (xfer_done) begin
         state_nx   = IDLE;
         ar_done_nx = 1'b0;
         aw_done_nx = 1'b0;
         w_done_nx  = 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: behavioural slave, simple masters, grant log.
// Expected grant order of the contention test depends on ARB_RR_EN.
module tb_axi_arbiter;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int SW = DW / 8;

   logic          ACLK = 1'b0;
   logic          ARESETn = 1'b0;
   logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic [AW-1:0] m0_araddr;
   logic [DW-1:0] m0_rdata;
   logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic [AW-1:0] m1_araddr, m1_awaddr;
   logic [DW-1:0] m1_rdata, m1_wdata;
   logic          m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
   logic [SW-1:0] m1_wstrb;
   logic          s_arvalid, s_arready, s_rvalid, s_rready;
   logic [AW-1:0] s_araddr, s_awaddr;
   logic [DW-1:0] s_rdata, s_wdata;
   logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [SW-1:0] s_wstrb;
   logic          any_out;

   always #5 ACLK = ~ACLK;

   axi_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready)
   );

   assign any_out = |{m0_arready, m0_rvalid, m0_rdata, m1_arready, m1_rvalid, m1_rdata,
                      m1_awready, m1_wready, m1_bvalid, s_arvalid, s_araddr, s_rready,
                      s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // slave model state
   int            cyc;
   bit            r_pend, aw_got, w_got, b_pend;
   int            r_cnt, aw_lat, w_lat, aw_wait, w_wait;
   logic [DW-1:0] rd_word;
   // observation
   int            ar_hs_n, aw_hs_n, w_hs_n, b_n, ar_cyc, aw_cyc, w_cyc, b_cyc, gn;
   int            glog [32];
   logic [AW-1:0] ar_addr_seen, aw_addr_seen;
   logic [DW-1:0] w_data_seen, m0_last_rdata, m1_last_rdata;
   logic [SW-1:0] w_strb_seen;
   bit            m1_act;
   // master model state
   bit            auto_m0, auto_m1, m0_busy, m1_busy;
   bit            drop_m0_ar, drop_m1_ar, drop_m1_aw, drop_m1_w;

   task automatic clear_stats();
      ar_hs_n = 0; aw_hs_n = 0; w_hs_n = 0; b_n = 0; gn = 0;
      ar_cyc = -1; aw_cyc = -1; w_cyc = -1; b_cyc = -1;
      ar_addr_seen = '0; aw_addr_seen = '0; w_data_seen = '0; w_strb_seen = '0;
      m0_last_rdata = '0; m1_last_rdata = '0; m1_act = 0;
      for (int i = 0; i < 32; i++) glog[i] = -1;
   endtask

   task automatic clear_models();
      m0_arvalid = 0; m0_araddr = '0; m0_rready = 1;
      m1_arvalid = 0; m1_araddr = '0; m1_rready = 1;
      m1_awvalid = 0; m1_awaddr = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_bready = 1;
      s_arready = 0; s_rvalid = 0; s_rdata = '0; s_awready = 0; s_wready = 0; s_bvalid = 0;
      r_pend = 0; r_cnt = 0; aw_got = 0; w_got = 0; b_pend = 0;
      aw_lat = 0; w_lat = 0; aw_wait = 0; w_wait = 0;
      auto_m0 = 0; auto_m1 = 0; m0_busy = 0; m1_busy = 0;
      drop_m0_ar = 0; drop_m1_ar = 0; drop_m1_aw = 0; drop_m1_w = 0;
      clear_stats();
   endtask

   task automatic issue_rd0(input logic [AW-1:0] a);
      m0_arvalid = 1; m0_araddr = a; m0_busy = 1;
   endtask

   task automatic issue_rd1(input logic [AW-1:0] a);
      m1_arvalid = 1; m1_araddr = a; m1_busy = 1;
   endtask

   task automatic issue_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      m1_awvalid = 1; m1_awaddr = a; m1_wvalid = 1; m1_wdata = d; m1_wstrb = s; m1_busy = 1;
   endtask

   task automatic slave_drive();
      s_arready = 1;
      if (r_pend) begin
         if (r_cnt > 0) r_cnt--;
         s_rvalid = (r_cnt == 0);
         s_rdata  = (r_cnt == 0) ? rd_word : '0;
      end else begin
         s_rvalid = 0;
         s_rdata  = '0;
      end
      s_awready = s_awvalid && (aw_wait >= aw_lat);
      s_wready  = s_wvalid && (w_wait >= w_lat);
      s_bvalid  = b_pend;
   endtask

   // Sampled just before the edge: any valid&&ready seen here completes at that edge.
   task automatic monitor();
      m1_act |= |{m1_arready, m1_rvalid, m1_rdata, m1_awready, m1_wready, m1_bvalid};
      if (s_arvalid && s_arready) begin
         ar_hs_n++; ar_cyc = cyc; ar_addr_seen = s_araddr; r_pend = 1; r_cnt = 3;
      end
      if (s_rvalid && s_rready) r_pend = 0;
      if (s_awvalid && s_awready) begin
         aw_hs_n++; aw_cyc = cyc; aw_addr_seen = s_awaddr; aw_got = 1; aw_wait = 0;
      end else if (s_awvalid) aw_wait++;
      if (s_wvalid && s_wready) begin
         w_hs_n++; w_cyc = cyc; w_data_seen = s_wdata; w_strb_seen = s_wstrb; w_got = 1; w_wait = 0;
      end else if (s_wvalid) w_wait++;
      if (s_bvalid && s_bready) begin
         b_pend = 0; aw_got = 0; w_got = 0;
      end else if (aw_got && w_got) b_pend = 1;
      if (m0_arvalid && m0_arready) drop_m0_ar = 1;
      if (m1_arvalid && m1_arready) drop_m1_ar = 1;
      if (m1_awvalid && m1_awready) drop_m1_aw = 1;
      if (m1_wvalid && m1_wready) drop_m1_w = 1;
      if (m0_rvalid && m0_rready) begin
         m0_last_rdata = m0_rdata; m0_busy = 0;
         if (gn < 32) glog[gn] = 0;
         gn++;
      end
      if (m1_rvalid && m1_rready) begin
         m1_last_rdata = m1_rdata; m1_busy = 0;
         if (gn < 32) glog[gn] = 1;
         gn++;
      end
      if (m1_bvalid && m1_bready) begin
         b_n++; b_cyc = cyc; m1_busy = 0;
         if (gn < 32) glog[gn] = 2;
         gn++;
      end
   endtask

   // Entered and left 1 time unit after a rising edge.
   task automatic step();
      #1 slave_drive();
      #1 monitor();
      @(posedge ACLK);
      #1;
      cyc++;
      if (drop_m0_ar) m0_arvalid = 0;
      if (drop_m1_ar) m1_arvalid = 0;
      if (drop_m1_aw) m1_awvalid = 0;
      if (drop_m1_w)  m1_wvalid = 0;
      drop_m0_ar = 0; drop_m1_ar = 0; drop_m1_aw = 0; drop_m1_w = 0;
      if (auto_m0 && !m0_busy) issue_rd0(32'h8000_0100);
      if (auto_m1 && !m1_busy) issue_rd1(32'h8000_0200);
   endtask

   task automatic run_until(input int target, input int budget, input string tag);
      int k = 0;
      while (gn < target && k < budget) begin
         step();
         k++;
      end
      check({tag, "_done"}, gn, target);
   endtask

   task automatic do_reset();
      ARESETn = 0;
      clear_models();
      #1 check("rst_hold_outs", any_out, 0);
      @(posedge ACLK);
      @(posedge ACLK);
      #1 ARESETn = 1;
   endtask

   initial begin
      int n0;
      int k;
      int zeros;
      logic [31:0] exp_g;
      cyc = 0;
      rd_word = '0;
      clear_models();
      @(posedge ACLK);
      #1 do_reset();
      step();
      check("post_rst_outs", any_out, 0);

      // reset mid RD_M0, after AR accepted and before R
      rd_word = 64'hDEAD_BEEF_0000_0001;
      issue_rd0(32'h8000_0000);
      k = 0;
      while (ar_hs_n == 0 && k < 10) begin step(); k++; end
      check("t1_ar_accepted", ar_hs_n, 1);
      step();
      s_rvalid = 1; s_rdata = rd_word;
      ARESETn = 0;
      #1;
      check("t1_rst_m0_rvalid", m0_rvalid, 0);
      check("t1_rst_m0_rdata", m0_rdata, 0);
      check("t1_rst_s_rready", s_rready, 0);
      do_reset();
      s_rvalid = 1; s_rdata = rd_word;
      #1;
      check("t1_idle_m0_rvalid", m0_rvalid, 0);
      check("t1_idle_s_valids", {s_arvalid, s_awvalid, s_wvalid}, 0);
      s_rvalid = 0; s_rdata = '0;

      // plain m0 read; also proves the arbiter came back in IDLE
      rd_word = 64'h1122_3344_5566_7788;
      n0 = cyc;
      issue_rd0(32'h8000_0000);
      run_until(1, 30, "t2");
      check("t2_ar_latency", ar_cyc - n0, 1);
      check("t2_araddr", ar_addr_seen, 32'h8000_0000);
      check("t2_rdata", m0_last_rdata, 64'h1122_3344_5566_7788);
      check("t2_m1_quiet", m1_act, 0);
      check("t2_grant", glog[0], 0);

      // simultaneous store and IFU load: store first, load 2 cycles after B
      clear_stats();
      rd_word = 64'h0F0E_0D0C_0B0A_0908;
      n0 = cyc;
      issue_wr(32'h8000_1000, 64'hAB, 8'h01);
      issue_rd0(32'h8000_0040);
      run_until(2, 40, "t3");
      check("t3_first_grant", glog[0], 2);
      check("t3_second_grant", glog[1], 0);
      check("t3_aw_latency", aw_cyc - n0, 1);
      check("t3_b_to_ar", ar_cyc - b_cyc, 2);
      check("t3_awaddr", aw_addr_seen, 32'h8000_1000);
      check("t3_wdata", w_data_seen, 64'hAB);
      check("t3_wstrb", w_strb_seen, 8'h01);
      check("t3_araddr", ar_addr_seen, 32'h8000_0040);
      check("t3_rdata", m0_last_rdata, 64'h0F0E_0D0C_0B0A_0908);

      // W accepted two cycles before AW
      clear_stats();
      aw_lat = 2;
      w_lat = 0;
      issue_wr(32'h8000_2000, 64'h5555, 8'hF0);
      run_until(1, 40, "t4");
      repeat (4) step();
      check("t4_w_count", w_hs_n, 1);
      check("t4_aw_count", aw_hs_n, 1);
      check("t4_b_count", b_n, 1);
      check("t4_w_before_aw", aw_cyc - w_cyc, 2);
      check("t4_awaddr", aw_addr_seen, 32'h8000_2000);
      check("t4_wdata", w_data_seen, 64'h5555);
      check("t4_wstrb", w_strb_seen, 8'hF0);
      aw_lat = 0;

      // continuous reads from both masters
      do_reset();
      rd_word = 64'h7777;
      issue_rd0(32'h8000_0100);
      issue_rd1(32'h8000_0200);
      auto_m0 = 1;
      auto_m1 = 1;
      run_until(6, 200, "t5");
      zeros = 0;
      for (int i = 0; i < 6; i++) begin
`ifdef ARB_RR_EN
         exp_g = (i % 2 == 0) ? 0 : 1;
`else
         exp_g = 1;
`endif
         check($sformatf("t5_grant%0d", i), glog[i], exp_g);
         if (glog[i] == 0) zeros++;
      end
`ifdef ARB_RR_EN
      check("t5_m0_share", zeros, 3);
`else
      check("t5_m0_starved", zeros, 0);
`endif
      check("t5_m1_rdata", m1_last_rdata, 64'h7777);
      auto_m0 = 0;
      auto_m1 = 0;
      k = 0;
      while ((m0_busy || m1_busy) && k < 60) begin step(); k++; end
      check("t5_drain", {m0_busy, m1_busy}, 0);
      check("t5_m0_served", m0_last_rdata, 64'h7777);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
